uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Consumes the byte stream from the UART receiver (one-cycle valid pulse plus byte) and extracts framed commands of the form SOF, CMD, LEN, PAYLOAD[LEN], CHK.
- Streams each payload byte downstream as it arrives.
- Issues one frame-done pulse per frame, carrying the command, the length and an error code.
- Sits between the UART receiver and the command-execution logic.
- Guards against stalled senders with an inter-byte timeout.

Parameters:
- SOF_BYTE, 8'hAA, start-of-frame marker.
- MAX_LEN, 8, maximum legal payload length (1..255).
- TIMEOUT_CLKS, 50000, clocks allowed between bytes inside a frame. Default ≈ 11.5 byte times at 433 clocks/bit.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  reset, asynchronous assert, active-low.
- i_Rx_DV  in  1  one-cycle byte-valid pulse from the UART receiver.
- i_Rx_Byte  in  8  received byte; valid when i_Rx_DV=1.
- o_Pld_DV  out  1  one-cycle pulse per payload byte.
- o_Pld_Byte  out  8  payload byte; valid with o_Pld_DV.
- o_Pld_Idx  out  8  index of the payload byte within the frame, 0-based.
- o_Frame_DV  out  1  one-cycle frame-complete pulse (success or error).
- o_Cmd  out  8  command byte of the current or last frame.
- o_Len  out  8  LEN byte of the current or last frame.
- o_Err  out  2  error code: 0 ok, 1 checksum, 2 length, 3 timeout. Valid with o_Frame_DV.
- o_Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: one clock; asynchronous, active-low. While i_Rst_L=0, all outputs are 0, state is IDLE, and all counters and the checksum are cleared. Reset mid-frame discards the frame and produces no o_Frame_DV.
- All outputs are registered. o_Pld_DV and o_Frame_DV assert exactly one cycle after the triggering i_Rx_DV cycle.
- States: IDLE, CMD, LEN, PAYLOAD, CHECK.
- IDLE:
  - on i_Rx_DV with byte==SOF_BYTE: go to CMD and clear chk.
  - any other byte is silently dropped.
- CMD: on i_Rx_DV, o_Cmd<=byte, chk<=byte, go to LEN.
- LEN, on i_Rx_DV:
  - o_Len<=byte, chk<=chk^byte.
  - byte>MAX_LEN: pulse o_Frame_DV with o_Err=2, go to IDLE.
  - byte==0: go to CHECK.
  - otherwise: go to PAYLOAD with index=0.
- PAYLOAD, on i_Rx_DV:
  - o_Pld_Byte<=byte, o_Pld_Idx<=index, pulse o_Pld_DV, chk<=chk^byte, index++.
  - when index==LEN-1, go to CHECK.
- CHECK: on i_Rx_DV, pulse o_Frame_DV with o_Err=0 if byte==chk, else o_Err=1. Go to IDLE.
- Checksum: 8-bit XOR over CMD, LEN and all payload bytes. SOF and CHK are excluded.
- Timeout:
  - 16-bit counter, cleared on every i_Rx_DV and in IDLE; increments each clock in the other states.
  - On reaching TIMEOUT_CLKS-1 without a byte: pulse o_Frame_DV with o_Err=3, go to IDLE.
  - If i_Rx_DV arrives in the same cycle the timeout would fire, the byte wins and the counter clears.
- A SOF_BYTE value received inside a frame is treated as data; there is no resynchronisation mid-frame.
- Back-to-back i_Rx_DV on consecutive cycles must be accepted with no loss, although the UART spaces them ≥10 bit times apart.
- o_Cmd and o_Len hold their values until the next frame's CMD or LEN byte. o_Pld_Byte and o_Pld_Idx hold until the next payload byte.
- The cycle after a frame ends, IDLE accepts a new SOF.

Decomposition:
- Shared package uart_frame_pkg holds:
  - the state encodings (3-bit);
  - the error codes ERR_OK, ERR_CHK, ERR_LEN, ERR_TMO;
  - the SOF_BYTE default.
- One natural sub-module: uart_frame_timer. It is the inter-byte timeout counter, with inputs clear and enable and a single expire pulse output.
- The FSM, checksum and index logic stay in the top module.

Test Plan:
- Good frame: AA 01 02 10 20 33 → two o_Pld_DV pulses (10 at idx0, 20 at idx1), then o_Frame_DV with Cmd=01, Len=02, Err=0, one cycle after the 33 byte.
- Bad checksum: AA 01 02 10 20 34 → payload pulses as above, then o_Frame_DV with Err=1.
- Length violation: AA 07 09 (MAX_LEN=8) → o_Frame_DV with Err=2, one cycle after the 09 byte, and no o_Pld_DV. A following AA 05 00 05 then yields Err=0 with Len=0 and no payload pulses.
- Garbage and timeout:
  - 55 13 AA 01 03 11 with no further byte → nothing for 55/13.
  - o_Pld_DV fires once (11).
  - o_Frame_DV with Err=3 fires exactly TIMEOUT_CLKS clocks after the 11 byte's valid, then o_Busy=0.
- Timeout tie: a byte is delivered exactly in the expiry cycle → no Err=3 and the frame continues normally.
- Reset mid-payload: assert i_Rst_L=0 after AA 01 04 10 → outputs go to 0 immediately (asynchronously). After release, a good frame parses correctly and no stale o_Frame_DV appears.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared encodings for the UART frame parser
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHECK   = 3'd4
   } state_t;

   localparam logic [1:0] ERR_OK  = 2'd0;
   localparam logic [1:0] ERR_CHK = 2'd1;
   localparam logic [1:0] ERR_LEN = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   localparam logic [7:0] SOF_BYTE_DEF = 8'hAA;

endpackage

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - inter-byte timeout counter with single-cycle expire
module uart_frame_timer #(
   parameter int TIMEOUT_CLKS = 50000
) (
   input  logic i_Clock,
   input  logic i_Rst_L,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CLKS - 1);

   logic [15:0] count;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         count <= '0;
      end else if (clear || !enable) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

   // An arriving byte suppresses expiry in the same cycle.
   assign expire = enable && !clear && (count == LAST_COUNT);

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - extracts SOF/CMD/LEN/PAYLOAD/CHK frames from a UART byte stream
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DEF,
   parameter int         MAX_LEN      = 8,
   parameter int         TIMEOUT_CLKS = 50000
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Pld_DV,
   output logic [7:0] o_Pld_Byte,
   output logic [7:0] o_Pld_Idx,
   output logic       o_Frame_DV,
   output logic [7:0] o_Cmd,
   output logic [7:0] o_Len,
   output logic [1:0] o_Err,
   output logic       o_Busy
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t     state_q, state_d;
   logic [7:0] chk_q, chk_d;
   logic [7:0] idx_q, idx_d;
   logic       pld_dv_d, frame_dv_d;
   logic [7:0] pld_byte_d, pld_idx_d, cmd_d, len_d;
   logic [1:0] err_d;
   logic       busy;
   logic       tmo_expire;

   assign busy   = (state_q != ST_IDLE);
   assign o_Busy = busy;

   uart_frame_timer #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_timer (
      .i_Clock(i_Clock),
      .i_Rst_L(i_Rst_L),
      .clear  (i_Rx_DV),
      .enable (busy),
      .expire (tmo_expire)
   );

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= ST_IDLE;
         chk_q      <= '0;
         idx_q      <= '0;
         o_Pld_DV   <= 1'b0;
         o_Pld_Byte <= '0;
         o_Pld_Idx  <= '0;
         o_Frame_DV <= 1'b0;
         o_Cmd      <= '0;
         o_Len      <= '0;
         o_Err      <= '0;
      end else begin
         state_q    <= state_d;
         chk_q      <= chk_d;
         idx_q      <= idx_d;
         o_Pld_DV   <= pld_dv_d;
         o_Pld_Byte <= pld_byte_d;
         o_Pld_Idx  <= pld_idx_d;
         o_Frame_DV <= frame_dv_d;
         o_Cmd      <= cmd_d;
         o_Len      <= len_d;
         o_Err      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      chk_d      = chk_q;
      idx_d      = idx_q;
      pld_dv_d   = 1'b0;
      pld_byte_d = o_Pld_Byte;
      pld_idx_d  = o_Pld_Idx;
      frame_dv_d = 1'b0;
      cmd_d      = o_Cmd;
      len_d      = o_Len;
      err_d      = o_Err;

      if (tmo_expire) begin
         frame_dv_d = 1'b1;
         err_d      = ERR_TMO;
         state_d    = ST_IDLE;
      end else if (i_Rx_DV) begin
         case (state_q)
            ST_IDLE: begin
               if (i_Rx_Byte == SOF_BYTE) begin
                  state_d = ST_CMD;
                  chk_d   = '0;
               end
            end
            ST_CMD: begin
               cmd_d   = i_Rx_Byte;
               chk_d   = i_Rx_Byte;
               state_d = ST_LEN;
            end
            ST_LEN: begin
               len_d = i_Rx_Byte;
               chk_d = chk_q ^ i_Rx_Byte;
               if (i_Rx_Byte > MAX_LEN_B) begin
                  frame_dv_d = 1'b1;
                  err_d      = ERR_LEN;
                  state_d    = ST_IDLE;
               end else if (i_Rx_Byte == 8'd0) begin
                  state_d = ST_CHECK;
               end else begin
                  idx_d   = '0;
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               pld_dv_d   = 1'b1;
               pld_byte_d = i_Rx_Byte;
               pld_idx_d  = idx_q;
               chk_d      = chk_q ^ i_Rx_Byte;
               idx_d      = idx_q + 8'd1;
               if (idx_q == 8'(o_Len - 8'd1)) begin
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               frame_dv_d = 1'b1;
               err_d      = (i_Rx_Byte == chk_q) ? ERR_OK : ERR_CHK;
               state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser
module tb_uart_frame_parser;

   localparam int TMO = 40;
   localparam int MAXL = 8;

   logic       i_Clock = 1'b0;
   logic       i_Rst_L = 1'b0;
   logic       i_Rx_DV = 1'b0;
   logic [7:0] i_Rx_Byte = 8'h00;
   logic       o_Pld_DV, o_Frame_DV, o_Busy;
   logic [7:0] o_Pld_Byte, o_Pld_Idx, o_Cmd, o_Len;
   logic [1:0] o_Err;

   uart_frame_parser #(
      .SOF_BYTE(8'hAA),
      .MAX_LEN(MAXL),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .i_Clock(i_Clock),
      .i_Rst_L(i_Rst_L),
      .i_Rx_DV(i_Rx_DV),
      .i_Rx_Byte(i_Rx_Byte),
      .o_Pld_DV(o_Pld_DV),
      .o_Pld_Byte(o_Pld_Byte),
      .o_Pld_Idx(o_Pld_Idx),
      .o_Frame_DV(o_Frame_DV),
      .o_Cmd(o_Cmd),
      .o_Len(o_Len),
      .o_Err(o_Err),
      .o_Busy(o_Busy)
   );

   always #5 i_Clock = ~i_Clock;

   int cyc = 0;
   always @(posedge i_Clock) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      logic [7:0] idx;
      int         cyc;
   } pld_ev_t;

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] len;
      logic [1:0] err;
      int         cyc;
   } frm_ev_t;

   pld_ev_t pld_q[$];
   frm_ev_t frm_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] gbuf[4];
   logic [7:0] pbuf[256];
   logic [7:0] m_cmd = 8'h00;
   logic [7:0] m_len = 8'h00;

   always @(negedge i_Clock) begin
      pld_ev_t pe;
      frm_ev_t fe;
      if (i_Rst_L && o_Pld_DV) begin
         n_cmp++;
         if (pld_q.size() == 0) begin
            n_bad++;
            $display("FAIL pld_unexpected: got byte=%h idx=%0d at cyc=%0d, required no payload pulse",
                     o_Pld_Byte, o_Pld_Idx, cyc);
         end else begin
            pe = pld_q.pop_front();
            if (o_Pld_Byte !== pe.b || o_Pld_Idx !== pe.idx || cyc != pe.cyc) begin
               n_bad++;
               $display("FAIL pld: got byte=%h idx=%0d cyc=%0d, required byte=%h idx=%0d cyc=%0d",
                        o_Pld_Byte, o_Pld_Idx, cyc, pe.b, pe.idx, pe.cyc);
            end
         end
      end
      if (i_Rst_L && o_Frame_DV) begin
         n_cmp++;
         if (frm_q.size() == 0) begin
            n_bad++;
            $display("FAIL frm_unexpected: got cmd=%h len=%h err=%0d at cyc=%0d, required no frame pulse",
                     o_Cmd, o_Len, o_Err, cyc);
         end else begin
            fe = frm_q.pop_front();
            if (o_Cmd !== fe.cmd || o_Len !== fe.len || o_Err !== fe.err || cyc != fe.cyc || o_Busy !== 1'b0) begin
               n_bad++;
               $display("FAIL frm: got cmd=%h len=%h err=%0d cyc=%0d busy=%b, required cmd=%h len=%h err=%0d cyc=%0d busy=0",
                        o_Cmd, o_Len, o_Err, cyc, o_Busy, fe.cmd, fe.len, fe.err, fe.cyc);
            end
         end
      end
   end

   task automatic check_zero(input string name);
      n_cmp++;
      if ({o_Pld_DV, o_Pld_Byte, o_Pld_Idx, o_Frame_DV, o_Cmd, o_Len, o_Err, o_Busy} !== '0) begin
         n_bad++;
         $display("FAIL %s: got pld_dv=%b pld=%h idx=%h frm_dv=%b cmd=%h len=%h err=%0d busy=%b, required all zero",
                  name, o_Pld_DV, o_Pld_Byte, o_Pld_Idx, o_Frame_DV, o_Cmd, o_Len, o_Err, o_Busy);
      end
   endtask

   // Plans the byte schedule, derives expected events from the frame's content, then drives it.
   // nsent: bytes after SOF to deliver (-1 = whole frame); tie_at: post-SOF byte that lands in the expiry cycle.
   task automatic do_frame(input int ngarb, input logic [7:0] cmd, input int len, input bit bad,
                           input int nsent, input int tie_at, input bit abort);
      logic [7:0] sb[$];
      logic [7:0] pb[$];
      int         sg[$];
      int         cy[$];
      int         f0, t, npl;
      logic [7:0] chk;
      for (int i = 0; i < ngarb; i++) sb.push_back(gbuf[i]);
      f0 = ngarb;
      sb.push_back(8'hAA);
      pb.push_back(cmd);
      pb.push_back(8'(len));
      chk = cmd ^ 8'(len);
      for (int i = 0; i < len; i++) begin
         pb.push_back(pbuf[i]);
         chk ^= pbuf[i];
      end
      pb.push_back(bad ? (chk ^ 8'h07) : chk);
      if (nsent < 0 || nsent > pb.size()) nsent = pb.size();
      if (len > MAXL && nsent > 2) nsent = 2;
      for (int j = 0; j < nsent; j++) sb.push_back(pb[j]);
      for (int k = 0; k < sb.size(); k++) begin
         sg.push_back((tie_at >= 0 && k + 1 == f0 + 1 + tie_at) ? TMO - 1 : int'($urandom_range(0, 4)));
      end
      t = cyc + 1;
      for (int k = 0; k < sb.size(); k++) begin
         cy.push_back(t);
         t += 1 + sg[k];
      end

      if (nsent >= 1) m_cmd = cmd;
      if (nsent >= 2) m_len = 8'(len);
      if (nsent >= 2 && len > MAXL) begin
         frm_q.push_back('{cmd: cmd, len: 8'(len), err: 2'd2, cyc: cy[f0 + 2]});
      end else begin
         npl = nsent - 2;
         if (npl < 0) npl = 0;
         if (npl > len) npl = len;
         for (int i = 0; i < npl; i++)
            pld_q.push_back('{b: pbuf[i], idx: 8'(i), cyc: cy[f0 + 3 + i]});
         if (nsent == len + 3)
            frm_q.push_back('{cmd: cmd, len: 8'(len), err: bad ? 2'd1 : 2'd0, cyc: cy[f0 + 3 + len]});
         else if (!abort)
            frm_q.push_back('{cmd: m_cmd, len: m_len, err: 2'd3, cyc: cy[sb.size() - 1] + TMO});
      end

      for (int k = 0; k < sb.size(); k++) begin
         i_Rx_Byte = sb[k];
         i_Rx_DV = 1'b1;
         @(posedge i_Clock);
         #1;
         i_Rx_DV = 1'b0;
         for (int g = 0; g < sg[k]; g++) begin
            @(posedge i_Clock);
            #1;
         end
      end
      if (!abort && nsent < len + 3 && !(len > MAXL && nsent == 2)) begin
         repeat (TMO + 5) @(posedge i_Clock);
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, len, ns, tie;
      #2;
      check_zero("reset_state");
      @(posedge i_Clock);
      #1;
      i_Rst_L = 1'b1;
      @(posedge i_Clock);
      #1;

      // good and bad-checksum frames
      pbuf[0] = 8'h10;
      pbuf[1] = 8'h20;
      do_frame(0, 8'h01, 2, 1'b0, -1, -1, 1'b0);
      do_frame(0, 8'h01, 2, 1'b1, -1, -1, 1'b0);

      // length violation then an empty-payload frame
      do_frame(0, 8'h07, 9, 1'b0, -1, -1, 1'b0);
      do_frame(0, 8'h05, 0, 1'b0, -1, -1, 1'b0);

      // leading garbage, then a stalled frame
      gbuf[0] = 8'h55;
      gbuf[1] = 8'h13;
      pbuf[0] = 8'h11;
      do_frame(2, 8'h01, 3, 1'b0, 3, -1, 1'b0);

      // a byte landing exactly in the expiry cycle
      pbuf[0] = 8'hAA;
      pbuf[1] = 8'h42;
      pbuf[2] = 8'h99;
      do_frame(0, 8'h3C, 3, 1'b0, -1, 3, 1'b0);
      do_frame(0, 8'h3D, 1, 1'b0, -1, 0, 1'b0);

      // reset in the middle of a payload
      pbuf[0] = 8'h10;
      do_frame(0, 8'h01, 4, 1'b0, 3, -1, 1'b1);
      n_cmp++;
      if (o_Busy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_mid_frame: got %b, required 1", o_Busy);
      end
      #2;
      i_Rst_L = 1'b0;
      #1;
      check_zero("async_reset");
      m_cmd = 8'h00;
      m_len = 8'h00;
      repeat (2) @(posedge i_Clock);
      #1;
      i_Rst_L = 1'b1;
      pbuf[0] = 8'h10;
      pbuf[1] = 8'h20;
      do_frame(0, 8'h01, 2, 1'b0, -1, -1, 1'b0);

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 5));
         len = int'($urandom_range(0, MAXL));
         for (int i = 0; i < 256; i++) pbuf[i] = 8'($urandom_range(0, 255));
         for (int i = 0; i < 4; i++) begin
            gbuf[i] = 8'($urandom_range(0, 255));
            if (gbuf[i] == 8'hAA) gbuf[i] = 8'h5A;
         end
         ns = -1;
         if (kind == 3) len = int'($urandom_range(MAXL + 1, 255));
         if (kind == 4) ns = int'($urandom_range(0, len + 2));
         tie = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 2)) : -1;
         do_frame(int'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), len, kind == 2, ns, tie, 1'b0);
      end

      repeat (10) @(posedge i_Clock);
      #1;
      n_cmp++;
      if (pld_q.size() != 0 || frm_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover: got %0d payload and %0d frame events pending, required 0 and 0",
                  pld_q.size(), frm_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
